addr_dec_resp_mux_varlat_mo: RTL and testbench
==============================================

Name: addr_dec_resp_mux_varlat_mo

Overview:
Master-side address decoder and response mux for the variable-latency TCDM crossbar, with multiple outstanding transactions. One master port fans out to NumOut bank ports. Up to MaxOutstanding requests may be in flight, provided they all target the same bank, so responses stay in order. Changing bank requires the in-flight count to drain to zero; a response arriving in the same cycle counts toward draining.

Parameters:
AggregateGnt, 0, 1: gnt_o = OR of gnt_i (still qualified by the issue rule); 0: gnt_o = gnt_i[add_i] qualified
NumOut, 32, number of slave/bank ports (>=1)
ReqDataWidth, 32, width of request payload
RespDataWidth, 32, width of response payload
MaxOutstanding, 4, maximum in-flight requests (>=1)
LogNumOut, NumOut>1 ? $clog2(NumOut) : 1, bank index width (derived)
CntWidth, $clog2(MaxOutstanding+1), counter width (derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  master request
add_i  in  LogNumOut  target bank index
data_i  in  ReqDataWidth  request payload
gnt_o  out  1  grant to master
vld_o  out  1  response valid
rdata_o  out  RespDataWidth  response data
outstanding_o  out  CntWidth  current in-flight count (cnt_q)
busy_o  out  1  cnt_q != 0
req_o  out  NumOut  decoded one-hot requests
gnt_i  in  NumOut  bank grants
vld_i  in  NumOut  bank response valids
data_o  out  NumOut x ReqDataWidth  request payload broadcast
rdata_i  in  NumOut x RespDataWidth  bank responses

Behaviour:
- Reset state: cnt_q = 0, bank_sel_q = 0. This gives vld_o = 0, busy_o = 0, outstanding_o = 0, and req_o = 0 unless req_i is high.
- rsp = vld_i[bank_sel_q] & (cnt_q != 0).
- vld_o = rsp. rdata_o = rdata_i[bank_sel_q], combinational, zero latency.
- eff = cnt_q - rsp.
- Issue rule: allowed = (eff == 0) | ((add_i == bank_sel_q) & (eff < MaxOutstanding)).
- For NumOut == 1, the bank compare is always true.
- req_o[add_i] = req_i & allowed. All other req_o bits are 0.
- gnt_o = allowed & (AggregateGnt ? |gnt_i : gnt_i[add_i]).
- data_o = data_i replicated to all ports.
- accept = req_i & gnt_o.
  - On accept, bank_sel_q <= add_i.
  - cnt_q <= cnt_q + accept - rsp.
  - Accept and response in the same cycle leave cnt_q unchanged.
- Full (cnt_q == MaxOutstanding, no rsp): req_o is gated to 0, gnt_o = 0, master stalls.
- Full with rsp in the same cycle: a same-bank request may issue.
- Bank switch: with cnt_q == 1, rsp = 1 and add_i != bank_sel_q, the request issues in that same cycle.
- Spurious responses:
  - vld_i from any bank while cnt_q == 0 is ignored.
  - vld_i from a bank other than bank_sel_q is ignored.
- Counter never wraps: it is bounded in 0..MaxOutstanding by the issue rule.
- Reset mid-operation: the counter clears and in-flight responses are dropped. Any bank responses after reset are ignored because cnt_q == 0.
- req_i deasserted while stalled is legal; no state changes.

Optional Feature:
ADDR_DEC_RESP_MUX_VARLAT_MO_RESP_REG_EN
- Defined:
  - vld_o and rdata_o come from a response register. Internal rsp is registered into vld_q/rdata_q, so response latency is +1 cycle.
  - vld_q resets to 0. rdata_q loads only when rsp = 1.
  - Counter accounting and the issue rule still use the internal, unregistered rsp.
  - Consequence: a response is visible on vld_o one cycle after cnt_q has already decremented.
- Undefined: combinational response path exactly as described above.

Test Plan:
1. Reset with req_i = 0 -> vld_o = 0, outstanding_o = 0, busy_o = 0, req_o = 0.
2. Pipelined same-bank traffic, MaxOutstanding = 4: 4 back-to-back requests to bank 3, gnt_i[3] = 1, no responses -> 4 grants, outstanding_o = 4. 5th request -> req_o = 0, gnt_o = 0. Pulse vld_i[3] with rdata_i[3] = 0xA5A5_0001 -> vld_o = 1, rdata_o = 0xA5A5_0001, and 5th request granted in the same cycle.
3. Bank switch blocking: 2 outstanding to bank 1, request to bank 5 -> stalled. First vld_i[1] -> still stalled (eff = 1). Second vld_i[1] -> req_o[5] = 1 in the same cycle.
4. Stray responses: cnt_q = 0, vld_i = all-ones -> vld_o = 0. With 1 outstanding to bank 2, vld_i[7] = 1 alone -> vld_o = 0, outstanding_o stays 1.
5. Simultaneous accept and response at cnt_q = 2, same bank -> outstanding_o stays 2. AggregateGnt = 1 case: gnt_i = 0x8000_0000, add_i = 0 -> gnt_o = 1 only when allowed.
6. Reset asserted with 3 outstanding -> outstanding_o = 0 immediately. After release, vld_i[bank] = 1 -> vld_o = 0. With RESP_REG_EN defined, scenario 2 responses appear exactly 1 cycle later.

Source files
------------

// File: rtl/addr_dec_resp_mux_varlat_mo_if.sv
// Bundles the master-side and bank-side signals of the variable-latency address decoder.
// The slave modport is the decoder's view. The master modport is the environment's view:
// it drives the master request and the bank replies.
interface addr_dec_resp_mux_varlat_mo_if #(
  parameter int unsigned NumOut         = 32,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned LogNumOut      = (NumOut > 1) ? $clog2(NumOut) : 1,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
);
  // Master side
  logic                     req;
  logic [LogNumOut-1:0]     add;
  logic [ReqDataWidth-1:0]  data;
  logic                     gnt;
  logic                     vld;
  logic [RespDataWidth-1:0] rdata;
  logic [CntWidth-1:0]      outstanding;
  logic                     busy;

  // Bank side
  logic [NumOut-1:0]                    bank_req;
  logic [NumOut-1:0]                    bank_gnt;
  logic [NumOut-1:0]                    bank_vld;
  logic [NumOut-1:0][ReqDataWidth-1:0]  bank_data;
  logic [NumOut-1:0][RespDataWidth-1:0] bank_rdata;

  modport master (
    output req, add, data, bank_gnt, bank_vld, bank_rdata,
    input  gnt, vld, rdata, outstanding, busy, bank_req, bank_data
  );

  modport slave (
    input  req, add, data, bank_gnt, bank_vld, bank_rdata,
    output gnt, vld, rdata, outstanding, busy, bank_req, bank_data
  );
endinterface

// File: rtl/addr_dec_resp_mux_varlat_mo.sv
// Master-side address decoder and response mux with multiple outstanding requests.
// All in-flight requests target a single bank so that responses return in order.
// A change of bank waits until the in-flight count drains to zero.
// Optional macro ADDR_DEC_RESP_MUX_VARLAT_MO_RESP_REG_EN registers vld/rdata, which adds
// one cycle of response latency. Counter accounting always uses the unregistered response.
module addr_dec_resp_mux_varlat_mo #(
  parameter bit          AggregateGnt   = 1'b0,
  parameter int unsigned NumOut         = 32,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned LogNumOut      = (NumOut > 1) ? $clog2(NumOut) : 1,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  addr_dec_resp_mux_varlat_mo_if.slave bus
);

  logic [CntWidth-1:0]  cnt_q, cnt_d, eff;
  logic [LogNumOut-1:0] bank_sel_q, bank_sel_d;
  logic                 rsp, same_bank, allowed, gnt_sel, accept;

  // A response counts only from the bank currently owning the in-flight requests.
  assign rsp       = bus.bank_vld[bank_sel_q] & (cnt_q != '0);
  assign eff       = cnt_q - CntWidth'(rsp);
  assign same_bank = (NumOut == 1) ? 1'b1 : (bus.add == bank_sel_q);
  assign allowed   = (eff == '0) | (same_bank & (eff < CntWidth'(MaxOutstanding)));
  assign gnt_sel   = AggregateGnt ? (|bus.bank_gnt) : bus.bank_gnt[bus.add];
  assign bus.gnt   = allowed & gnt_sel;
  assign accept    = bus.req & bus.gnt;

  assign bus.bank_data   = {NumOut{bus.data}};
  assign bus.outstanding = cnt_q;
  assign bus.busy        = (cnt_q != '0);

  // One-hot request decode, gated by the issue rule
  always_comb begin
    bus.bank_req          = '0;
    bus.bank_req[bus.add] = bus.req & allowed;
  end

  // Next-state: track in-flight count and owning bank
  always_comb begin
    cnt_d      = cnt_q + CntWidth'(accept) - CntWidth'(rsp);
    bank_sel_d = bank_sel_q;
    if (accept) begin
      bank_sel_d = bus.add;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      bank_sel_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      bank_sel_q <= bank_sel_d;
    end
  end

`ifdef ADDR_DEC_RESP_MUX_VARLAT_MO_RESP_REG_EN
  logic                     vld_q;
  logic [RespDataWidth-1:0] rdata_q;

  // Response register; data holds its value between responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      vld_q <= rsp;
      if (rsp) begin
        rdata_q <= bus.bank_rdata[bank_sel_q];
      end
    end
  end

  assign bus.vld   = vld_q;
  assign bus.rdata = rdata_q;
`else
  assign bus.vld   = rsp;
  assign bus.rdata = bus.bank_rdata[bank_sel_q];
`endif

endmodule

// File: tb/tb_addr_dec_resp_mux_varlat_mo.sv
// Self-checking bench for addr_dec_resp_mux_varlat_mo. Expected responses go into a
// scoreboard queue, tagged with the cycle in which they must appear on vld_o.
module tb_addr_dec_resp_mux_varlat_mo;
  localparam int unsigned NumOut = 32;
  localparam int unsigned Dw     = 32;
  localparam int unsigned MaxOut = 4;
`ifdef ADDR_DEC_RESP_MUX_VARLAT_MO_RESP_REG_EN
  localparam int RespLat = 1;
`else
  localparam int RespLat = 0;
`endif

  typedef struct {
    logic [Dw-1:0] data;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  exp_t sb[$];

  addr_dec_resp_mux_varlat_mo_if #(.NumOut(NumOut), .MaxOutstanding(MaxOut)) bus_a ();
  addr_dec_resp_mux_varlat_mo_if #(.NumOut(NumOut), .MaxOutstanding(MaxOut)) bus_b ();

  addr_dec_resp_mux_varlat_mo #(
    .AggregateGnt(1'b0), .NumOut(NumOut), .MaxOutstanding(MaxOut)
  ) dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a)
  );

  addr_dec_resp_mux_varlat_mo #(
    .AggregateGnt(1'b1), .NumOut(NumOut), .MaxOutstanding(MaxOut)
  ) dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every vld_o must match the oldest expected response, in the expected cycle
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_vld: no vld_o by cycle %0d, required data %08h",
               sb[0].cyc, sb[0].data);
      void'(sb.pop_front());
    end
    if (bus_a.vld === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_vld: vld_o=1 rdata=%08h at cycle %0d, none expected",
                 bus_a.rdata, cyc);
      end else begin
        if (bus_a.rdata !== sb[0].data || cyc != sb[0].cyc) begin
          miscompares++;
          $display("FAIL resp: got %08h at cycle %0d, required %08h at cycle %0d",
                   bus_a.rdata, cyc, sb[0].data, sb[0].cyc);
        end
        void'(sb.pop_front());
      end
    end else if (bus_a.vld !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL vld_x: vld_o=%b at cycle %0d", bus_a.vld, cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse one bank response this cycle; if expect_it, it must appear on vld_o
  task automatic set_rsp(input int bank, input logic [Dw-1:0] d, input bit expect_it);
    exp_t e;
    bus_a.bank_vld           = '0;
    bus_a.bank_vld[bank]     = 1'b1;
    bus_a.bank_rdata[bank]   = d;
    if (expect_it) begin
      e.data = d;
      e.cyc  = cyc + RespLat;
      sb.push_back(e);
    end
  endtask

  task automatic clear_rsp();
    bus_a.bank_vld = '0;
    for (int k = 0; k < NumOut; k++) bus_a.bank_rdata[k] = 32'h0101_0101 * k;
  endtask

  task automatic issue_a(input int bank, input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.req = 1'b1;
      bus_a.add = 5'(bank);
      bus_a.data = 32'hD000_0000 + i;
      tick();
    end
    bus_a.req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.req = 1'b0; bus_a.add = '0; bus_a.data = '0; bus_a.bank_gnt = '0;
    bus_b.req = 1'b0; bus_b.add = '0; bus_b.data = '0; bus_b.bank_gnt = '0;
    bus_b.bank_vld = '0; bus_b.bank_rdata = '0;
    clear_rsp();
    #12;
    vectors++;
    if (bus_a.vld !== 1'b0 || bus_a.outstanding !== 3'd0 || bus_a.busy !== 1'b0 ||
        bus_a.bank_req !== '0) begin
      miscompares++;
      $display("FAIL reset: vld=%b outst=%0d busy=%b req_o=%08h, required 0 0 0 0",
               bus_a.vld, bus_a.outstanding, bus_a.busy, bus_a.bank_req);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pipelined();
    bus_a.bank_gnt = 32'h0000_0008;
    for (int i = 0; i < 4; i++) begin
      bus_a.req = 1'b1; bus_a.add = 5'd3; bus_a.data = 32'hC0DE_0000 + i;
      #1;
      vectors++;
      if (bus_a.bank_req !== 32'h8 || bus_a.gnt !== 1'b1 ||
          bus_a.bank_data[17] !== 32'hC0DE_0000 + i) begin
        miscompares++;
        $display("FAIL pipe_issue%0d: req_o=%08h gnt=%b data17=%08h, required 00000008 1 %08h",
                 i, bus_a.bank_req, bus_a.gnt, bus_a.bank_data[17], 32'hC0DE_0000 + i);
      end
      tick();
    end
    vectors++;
    if (bus_a.outstanding !== 3'd4 || bus_a.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pipe_full: outst=%0d busy=%b, required 4 1", bus_a.outstanding, bus_a.busy);
    end
    #1;
    vectors++;
    if (bus_a.bank_req !== '0 || bus_a.gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL pipe_stall: req_o=%08h gnt=%b, required 0 0", bus_a.bank_req, bus_a.gnt);
    end
    tick();
    set_rsp(3, 32'hA5A5_0001, 1'b1);
    #1;
    vectors++;
    if (bus_a.bank_req !== 32'h8 || bus_a.gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL pipe_full_rsp: req_o=%08h gnt=%b, required 00000008 1",
               bus_a.bank_req, bus_a.gnt);
    end
    tick();
    bus_a.req = 1'b0;
    clear_rsp();
    vectors++;
    if (bus_a.outstanding !== 3'd4) begin
      miscompares++;
      $display("FAIL pipe_keep: outst=%0d, required 4", bus_a.outstanding);
    end
    for (int i = 0; i < 4; i++) begin
      set_rsp(3, 32'hA5A5_0002 + i, 1'b1);
      tick();
    end
    clear_rsp();
    vectors++;
    if (bus_a.outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL pipe_drain: outst=%0d, required 0", bus_a.outstanding);
    end
    tick();
  endtask

  task automatic test_bank_switch();
    bus_a.bank_gnt = '1;
    issue_a(1, 2);
    bus_a.req = 1'b1; bus_a.add = 5'd5;
    #1;
    vectors++;
    if (bus_a.bank_req !== '0 || bus_a.gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_stall: req_o=%08h gnt=%b, required 0 0", bus_a.bank_req, bus_a.gnt);
    end
    tick();
    set_rsp(1, 32'h1111_0001, 1'b1);
    #1;
    vectors++;
    if (bus_a.bank_req !== '0 || bus_a.gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_eff1: req_o=%08h gnt=%b, required 0 0", bus_a.bank_req, bus_a.gnt);
    end
    tick();
    set_rsp(1, 32'h1111_0002, 1'b1);
    #1;
    vectors++;
    if (bus_a.bank_req !== 32'h20 || bus_a.gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_go: req_o=%08h gnt=%b, required 00000020 1", bus_a.bank_req, bus_a.gnt);
    end
    tick();
    bus_a.req = 1'b0;
    clear_rsp();
    vectors++;
    if (bus_a.outstanding !== 3'd1) begin
      miscompares++;
      $display("FAIL sw_cnt: outst=%0d, required 1", bus_a.outstanding);
    end
    set_rsp(5, 32'h5555_0005, 1'b1);
    tick();
    clear_rsp();
    tick();
  endtask

  task automatic test_stray();
    bus_a.bank_vld = '1;
    tick();
    clear_rsp();
    vectors++;
    if (bus_a.outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL stray_idle: outst=%0d, required 0", bus_a.outstanding);
    end
    issue_a(2, 1);
    set_rsp(7, 32'h7777_0007, 1'b0);
    tick();
    clear_rsp();
    vectors++;
    if (bus_a.outstanding !== 3'd1) begin
      miscompares++;
      $display("FAIL stray_other: outst=%0d, required 1", bus_a.outstanding);
    end
    set_rsp(2, 32'h2222_0002, 1'b1);
    tick();
    clear_rsp();
    tick();
  endtask

  task automatic test_back_to_back();
    issue_a(4, 2);
    bus_a.req = 1'b1; bus_a.add = 5'd4;
    set_rsp(4, 32'h4444_0001, 1'b1);
    #1;
    vectors++;
    if (bus_a.gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gnt: gnt=%b, required 1", bus_a.gnt);
    end
    tick();
    bus_a.req = 1'b0;
    clear_rsp();
    vectors++;
    if (bus_a.outstanding !== 3'd2) begin
      miscompares++;
      $display("FAIL b2b_cnt: outst=%0d, required 2", bus_a.outstanding);
    end
    set_rsp(4, 32'h4444_0002, 1'b1);
    tick();
    set_rsp(4, 32'h4444_0003, 1'b1);
    tick();
    clear_rsp();
    tick();
  endtask

  task automatic test_aggregate();
    bus_b.bank_gnt = 32'h8000_0000;
    bus_b.req = 1'b1; bus_b.add = 5'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (bus_b.gnt !== 1'b1 || bus_b.bank_req !== 32'h1) begin
        miscompares++;
        $display("FAIL agg_gnt%0d: gnt=%b req_o=%08h, required 1 00000001",
                 i, bus_b.gnt, bus_b.bank_req);
      end
      tick();
    end
    #1;
    vectors++;
    if (bus_b.gnt !== 1'b0 || bus_b.outstanding !== 3'd4) begin
      miscompares++;
      $display("FAIL agg_full: gnt=%b outst=%0d, required 0 4", bus_b.gnt, bus_b.outstanding);
    end
    bus_b.add = 5'd1;
    #1;
    vectors++;
    if (bus_b.gnt !== 1'b0 || bus_b.bank_req !== '0) begin
      miscompares++;
      $display("FAIL agg_switch: gnt=%b req_o=%08h, required 0 0", bus_b.gnt, bus_b.bank_req);
    end
    bus_b.req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus_a.bank_gnt = '1;
    issue_a(6, 3);
    vectors++;
    if (bus_a.outstanding !== 3'd3) begin
      miscompares++;
      $display("FAIL rst_pre: outst=%0d, required 3", bus_a.outstanding);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_a.outstanding !== 3'd0 || bus_a.busy !== 1'b0 || bus_b.outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_async: outst=%0d busy=%b outst_b=%0d, required 0 0 0",
               bus_a.outstanding, bus_a.busy, bus_b.outstanding);
    end
    tick();
    rst_n = 1'b1;
    set_rsp(6, 32'h6666_0006, 1'b0);
    tick();
    clear_rsp();
    vectors++;
    if (bus_a.outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_post: outst=%0d, required 0", bus_a.outstanding);
    end
    tick();
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    test_reset();
    test_pipelined();
    test_bank_switch();
    test_stray();
    test_back_to_back();
    test_aggregate();
    test_reset_mid();
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_empty: %0d responses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
